log_offset_lut_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one registered log-offset LUT (`lut_log_offset`, 4-bit `shift_offset` in, 24-bit `log_offset` out, one-cycle registered latency) between `NUM_REQ` requesters in the 4-bit fractional PE. Each requester presents a shift offset with a valid/ready handshake. The arbiter drives the LUT, captures the result and returns it to the winning requester on a per-requester valid/ready response channel. Only one lookup is in flight at a time.

---
 rtl/log_offset_lut_arbiter.sv | 112 +++++++++++
 tb/tb_log_offset_lut_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_offset_lut_arbiter.sv
// Round-robin arbiter sharing one registered log-offset LUT between requesters.
// One lookup in flight; result returned on a per-requester valid/ready channel.
module log_offset_lut_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int OFFSET_W = 4,
    parameter int DATA_W   = 24
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*OFFSET_W-1:0]  req_offset,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [OFFSET_W-1:0]          lut_shift_offset,
    input  logic [DATA_W-1:0]            lut_log_offset,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [DATA_W-1:0]            rsp_data,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic                         busy
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        LOOKUP,
        RESP
    } state_t;

    state_t              r_state;
    logic [IDW-1:0]      r_rr_ptr;
    logic [IDW-1:0]      r_gnt_id;
    logic [OFFSET_W-1:0] r_shift;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic                r_busy;

    logic                w_found;
    logic [IDW-1:0]      w_gnt;
    int                  w_idx;

    // Search upward from the pointer, wrapping; first valid bit wins.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_idx[IDW-1:0];
            end
        end
    end

    // Gated by rst_n so ready is zero while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && r_state == IDLE && w_found) begin
            req_ready = NUM_REQ'(1) << w_gnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_gnt_id    <= '0;
            r_shift     <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= '0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_shift  <= req_offset[w_gnt*OFFSET_W +: OFFSET_W];
                        r_gnt_id <= w_gnt;
                        r_rr_ptr <= (w_gnt == IDW'(NUM_REQ - 1)) ?
                                    '0 : w_gnt + 1'b1;
                        r_state  <= ISSUE;
                        r_busy   <= 1'b1;
                    end
                end
                ISSUE: begin
                    r_state <= LOOKUP;
                end
                LOOKUP: begin
                    r_rsp_data  <= lut_log_offset;
                    r_rsp_valid <= NUM_REQ'(1) << r_gnt_id;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[r_gnt_id]) begin
                        r_rsp_valid <= '0;
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign lut_shift_offset = r_shift;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_data         = r_rsp_data;
    assign busy             = r_busy;

endmodule

// File: tb/tb_log_offset_lut_arbiter.sv
// Directed bench for log_offset_lut_arbiter with a registered LUT model.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_log_offset_lut_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [15:0] req_offset = '0;
    logic [3:0]  req_ready;
    logic [3:0]  lut_shift_offset;
    logic [23:0] lut_log_offset = '0;
    logic [3:0]  rsp_valid;
    logic [23:0] rsp_data;
    logic [3:0]  rsp_ready = '0;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;

    log_offset_lut_arbiter #(
        .NUM_REQ(4),
        .OFFSET_W(4),
        .DATA_W(24)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_offset(req_offset),
        .req_ready(req_ready),
        .lut_shift_offset(lut_shift_offset),
        .lut_log_offset(lut_log_offset),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_ready(rsp_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] lut_fn(input logic [3:0] off);
        case (off)
            4'd0:    lut_fn = 24'h000000;
            4'd2:    lut_fn = 24'h00A98A;
            4'd3:    lut_fn = 24'h00F44F;
            4'd4:    lut_fn = 24'h009A29;
            4'd12:   lut_fn = 24'h004B04;
            4'd13:   lut_fn = 24'h00CBFC;
            default: lut_fn = {20'hA5000, off};
        endcase
    endfunction

    always @(posedge clk) lut_log_offset <= lut_fn(lut_shift_offset);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic bad;
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({req_ready, rsp_valid, busy} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_ctl: got rdy=%b vld=%b busy=%b, want 0",
                     req_ready, rsp_valid, busy);
        end
        n_checks++;
        if ({lut_shift_offset, rsp_data} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_data: got off=%h data=%h, want 0",
                     lut_shift_offset, rsp_data);
        end
        rst_n = 1'b1;
        tick();
        // requester 1 offset 3, abort during LOOKUP
        req_valid = 4'b0010;
        req_offset[4 +: 4] = 4'd3;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL abort_grant: got %b want 0010", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, busy, lut_shift_offset, rsp_data}
            !== 37'd0) begin
            n_fail++;
            $display("FAIL async_reset: rdy=%b vld=%b busy=%b off=%h d=%h",
                     req_ready, rsp_valid, busy, lut_shift_offset, rsp_data);
        end
        tick();
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid !== 4'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL no_rsp_after_abort: got bad=%b want 0", bad);
        end
        // pointer back at 0: requester 0 wins over 1
        req_valid = 4'b0011;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rr_ptr_reset: got %b want 0001", req_ready);
        end
        req_valid = '0;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL withdrawn_req: busy got %b want 0", busy);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_g [5];
        logic [23:0] exp_d [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_d = '{24'h00F44F, 24'h009A29, 24'h004B04, 24'h000000, 24'h00F44F};
        rsp_ready = 4'hF;
        req_offset = {4'd0, 4'd12, 4'd4, 4'd3};
        req_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (req_ready !== exp_g[i]) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got %b want %b",
                         i, req_ready, exp_g[i]);
            end
            tick();
            if (i == 4) req_valid = '0;
            tick();
            n_checks++;
            if (rsp_valid !== 4'b0) begin
                n_fail++;
                $display("FAIL rr_early%0d: got %b want 0", i, rsp_valid);
            end
            tick();
            n_checks++;
            if (rsp_valid !== exp_g[i] || rsp_data !== exp_d[i]) begin
                n_fail++;
                $display("FAIL rr_rsp%0d: got %b/%h want %b/%h",
                         i, rsp_valid, rsp_data, exp_g[i], exp_d[i]);
            end
            tick();
        end
    endtask

    task automatic test_single();
        rsp_ready = 4'hF;
        req_offset[8 +: 4] = 4'b0010;
        req_valid = 4'b0100;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_ready: got %b want 0100", req_ready);
        end
        tick();
        req_valid = '0;
        n_checks++;
        if (busy !== 1'b1 || lut_shift_offset !== 4'd2) begin
            n_fail++;
            $display("FAIL single_issue: busy=%b off=%h want 1/2",
                     busy, lut_shift_offset);
        end
        tick();
        tick();
        n_checks++;
        if (rsp_valid !== 4'b0100 || rsp_data !== 24'h00A98A) begin
            n_fail++;
            $display("FAIL single_rsp: got %b/%h want 0100/00a98a",
                     rsp_valid, rsp_data);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 4'b0) begin
            n_fail++;
            $display("FAIL single_done: busy=%b vld=%b want 0/0",
                     busy, rsp_valid);
        end
        n_checks++;
        if (lut_shift_offset !== 4'd2) begin
            n_fail++;
            $display("FAIL offset_hold: got %h want 2", lut_shift_offset);
        end
    endtask

    task automatic test_backpressure();
        logic bad;
        rsp_ready = 4'b0010;
        req_offset[0 +: 4] = 4'b1101;
        req_offset[4 +: 4] = 4'd4;
        req_valid = 4'b0001;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL bp_grant: got %b want 0001", req_ready);
        end
        tick();
        req_valid = 4'b0010;
        bad = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            if (req_ready !== 4'b0) bad = 1'b1;
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            if (rsp_valid !== 4'b0001 || rsp_data !== 24'h00CBFC) bad = 1'b1;
            if (req_ready !== 4'b0) bad = 1'b1;
            tick();
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: got bad=%b want 0", bad);
        end
        rsp_ready = 4'b0011;
        #1;
        n_checks++;
        if (rsp_valid !== 4'b0001 || req_ready !== 4'b0) begin
            n_fail++;
            $display("FAIL bp_handshake: vld=%b rdy=%b want 0001/0000",
                     rsp_valid, req_ready);
        end
        tick();
        n_checks++;
        if (req_ready !== 4'b0010 || rsp_valid !== 4'b0) begin
            n_fail++;
            $display("FAIL bp_next: rdy=%b vld=%b want 0010/0000",
                     req_ready, rsp_valid);
        end
        tick();
        req_valid = '0;
        tick();
        tick();
        n_checks++;
        if (rsp_valid !== 4'b0010 || rsp_data !== 24'h009A29) begin
            n_fail++;
            $display("FAIL bp_second: got %b/%h want 0010/009a29",
                     rsp_valid, rsp_data);
        end
        tick();
        rsp_ready = 4'hF;
    endtask

    task automatic test_wrap_around();
        // advance pointer to 3 via requester 2
        req_offset[8 +: 4] = 4'd0;
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        tick();
        tick();
        tick();
        req_offset[0 +: 4] = 4'd12;
        req_offset[12 +: 4] = 4'd4;
        req_valid = 4'b1001;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL wrap_first: got %b want 1000", req_ready);
        end
        tick();
        req_valid = 4'b0001;
        tick();
        tick();
        n_checks++;
        if (rsp_valid !== 4'b1000 || rsp_data !== 24'h009A29) begin
            n_fail++;
            $display("FAIL wrap_rsp3: got %b/%h want 1000/009a29",
                     rsp_valid, rsp_data);
        end
        tick();
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_second: got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
        tick();
        n_checks++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 24'h004B04) begin
            n_fail++;
            $display("FAIL wrap_rsp0: got %b/%h want 0001/004b04",
                     rsp_valid, rsp_data);
        end
        tick();
        req_valid = 4'b0011;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL wrap_ptr1: got %b want 0010", req_ready);
        end
        req_valid = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_wrap_around();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
